quantdeser: RTL and testbench

QUANTDESER -- requirements
Module: quantdeser

---
 rtl/quantdeser.sv | 111 +++++++++++
 tb/tb_quantdeser.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/quantdeser.sv
// quantdeser: multi-lane serial-to-parallel deserializer.
//
// Each of NLANES lanes delivers a bd-bit word MSB first, one bit per clock.
// A frame is armed by start in IDLE, and bd = bdout+1 is latched at that
// edge. The next bd edges shift one bit into every lane. The completed words
// are LSB-aligned and zero-extended in dout. Then ovalid is held until the
// consumer accepts with ordy.
//
// Ports:
//   clk      in   rising-edge clock
//   clr      in   synchronous active-high reset
//   bdout    in   BDOP     bit depth minus 1, sampled only with start in IDLE
//   start    in   1        frame start
//   din      in   NLANES   serial bit per lane, lane i on din[i]
//   dout     out  NLANES*BDOUTMAX  words, lane i on dout[i*BDOUTMAX +: BDOUTMAX]
//   ovalid   out  1        dout holds a complete frame
//   ordy     in   1        consumer accepts dout when ovalid && ordy
//   busy     out  1        a frame is being shifted in
//   overflow out  1        sticky: an unaccepted frame was overwritten
//   starterr out  1        sticky: start arrived while busy
module quantdeser #(
  parameter int NLANES   = 8,
  parameter int BDOUTMAX = 32,
  parameter int BDOP     = $clog2(BDOUTMAX)
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic [BDOP-1:0]              bdout,
  input  logic                         start,
  input  logic [NLANES-1:0]            din,
  output logic [NLANES*BDOUTMAX-1:0]   dout,
  output logic                         ovalid,
  input  logic                         ordy,
  output logic                         busy,
  output logic                         overflow,
  output logic                         starterr
);

  // One extra bit so the counter can hold bd = BDOUTMAX.
  localparam int CW = BDOP + 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                       state, state_nxt;
  logic [CW-1:0]                cnt;
  logic [NLANES*BDOUTMAX-1:0]   sr, sr_nxt;
  logic                         last;

  // The edge that shifts in the final bit of the frame.
  assign last = (state == SHIFT) && (cnt == CW'(1));
  assign busy = (state == SHIFT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Every lane shifts left and takes its new bit at bit 0. The registers are
  // cleared at start, so the bits above bd-1 stay zero.
  always_comb begin
    sr_nxt = '0;
    for (int i = 0; i < NLANES; i++) begin
      sr_nxt[i*BDOUTMAX +: BDOUTMAX] = {sr[i*BDOUTMAX +: BDOUTMAX-1], din[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---- shift stage / output register boundary ----
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt      <= '0;
      sr       <= '0;
      dout     <= '0;
      ovalid   <= 1'b0;
      overflow <= 1'b0;
      starterr <= 1'b0;
    end else begin
      if (state == IDLE) begin
        if (start) begin
          cnt <= CW'(bdout) + CW'(1);
          sr  <= '0;
        end
      end else begin
        sr  <= sr_nxt;
        cnt <= cnt - CW'(1);
        // A start at any edge in SHIFT is ignored. This includes the
        // completing edge.
        if (start) starterr <= 1'b1;
      end

      if (last) begin
        // A new frame always replaces dout. It counts as a loss only when
        // the previous frame is still pending and is not taken at this edge.
        dout   <= sr_nxt;
        ovalid <= 1'b1;
        if (ovalid && !ordy) overflow <= 1'b1;
      end else if (ovalid && ordy) begin
        ovalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quantdeser.sv
module tb_quantdeser;

  localparam int NL = 8;
  localparam int BM = 32;
  localparam int BP = 5;
  localparam int DW = NL * BM;

  logic          clk = 1'b0;
  logic          clr;
  logic [BP-1:0] bdout;
  logic          start;
  logic [NL-1:0] din;
  logic [DW-1:0] dout;
  logic          ovalid;
  logic          ordy;
  logic          busy;
  logic          overflow;
  logic          starterr;

  int total = 0;
  int passed = 0;

  quantdeser #(.NLANES(NL), .BDOUTMAX(BM), .BDOP(BP)) dut (
    .clk(clk), .clr(clr), .bdout(bdout), .start(start), .din(din),
    .dout(dout), .ovalid(ovalid), .ordy(ordy), .busy(busy),
    .overflow(overflow), .starterr(starterr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          bdo;
    logic [31:0] in0, in1, in7;
    logic [31:0] exp0, exp1, exp7;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic logic [DW-1:0] words(input logic [31:0] w0, w1, w7);
    logic [DW-1:0] d;
    d = '0;
    d[0*BM +: BM] = w0;
    d[1*BM +: BM] = w1;
    d[7*BM +: BM] = w7;
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic accept();
    ordy = 1'b1;
    step();
    ordy = 1'b0;
  endtask

  // Sends one frame. Lanes 0, 1 and 7 carry the low bd bits of v0, v1 and v7,
  // MSB first. The other lanes send 0. restart_k >= 0 raises start again
  // at edge E(restart_k+1). The call returns 1 ns after the completing edge.
  task automatic run_frame(input int bdo, input logic [31:0] v0, v1, v7,
                           input bit ordy_last, input int restart_k, input bit chk_lat);
    int bd;
    bd = bdo + 1;
    bdout = BP'(bdo);
    start = 1'b1;
    step();                                   // E0
    start = 1'b0;
    bdout = BP'($urandom);
    chk("busy_after_start", DW'(busy), DW'(1));
    for (int k = 0; k < bd; k++) begin
      din = '0;
      din[0] = v0[bd-1-k];
      din[1] = v1[bd-1-k];
      din[7] = v7[bd-1-k];
      if (k == restart_k) start = 1'b1;
      if (k == bd - 1) begin
        ordy = ordy_last;
        if (chk_lat) chk("ovalid_before_last", DW'(ovalid), DW'(0));
      end
      step();
      start = 1'b0;
      ordy  = 1'b0;
    end
    din = NL'($urandom);
  endtask

  initial begin
    clr = 1'b0; bdout = '0; start = 1'b0; din = '0; ordy = 1'b0;
    vecs[0] = '{bdo: 1,  in0: 32'h2,        in1: 32'h1, in7: 32'h0,  exp0: 32'h2,        exp1: 32'h1, exp7: 32'h0};
    vecs[1] = '{bdo: 31, in0: 32'h00000005, in1: 32'h0, in7: 32'h0,  exp0: 32'h00000005, exp1: 32'h0, exp7: 32'h0};
    vecs[2] = '{bdo: 31, in0: 32'hDEADBEEF, in1: 32'h80000001, in7: 32'hFFFFFFFF,
                exp0: 32'hDEADBEEF, exp1: 32'h80000001, exp7: 32'hFFFFFFFF};
    vecs[3] = '{bdo: 3,  in0: 32'hFF,       in1: 32'h5, in7: 32'hA,  exp0: 32'hF,        exp1: 32'h5, exp7: 32'hA};
    vecs[4] = '{bdo: 7,  in0: 32'h1A5,      in1: 32'h3C, in7: 32'h80, exp0: 32'hA5,      exp1: 32'h3C, exp7: 32'h80};
    vecs[5] = '{bdo: 0,  in0: 32'h0,        in1: 32'h3, in7: 32'h1,  exp0: 32'h0,        exp1: 32'h1, exp7: 32'h1};

    step();
    clr = 1'b1; start = 1'b1;   // clr overrides start
    step();
    step();
    clr = 1'b0; start = 1'b0;
    chk("rst_dout", dout, '0);
    chk("rst_ovalid", DW'(ovalid), DW'(0));
    chk("rst_busy", DW'(busy), DW'(0));
    chk("rst_overflow", DW'(overflow), DW'(0));
    chk("rst_starterr", DW'(starterr), DW'(0));

    // One-bit frame: busy lasts exactly one cycle.
    run_frame(0, 32'h1, 32'h0, 32'h0, 1'b0, -1, 1'b1);
    chk("bd1_ovalid", DW'(ovalid), DW'(1));
    chk("bd1_busy_low", DW'(busy), DW'(0));
    chk("bd1_dout", dout, words(32'h1, 32'h0, 32'h0));
    accept();
    chk("bd1_accept", DW'(ovalid), DW'(0));

    // ordy has no effect while ovalid is low.
    ordy = 1'b1;
    step();
    ordy = 1'b0;
    chk("ordy_idle_dout", dout, words(32'h1, 32'h0, 32'h0));

    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].bdo, vecs[v].in0, vecs[v].in1, vecs[v].in7, 1'b0, -1, 1'b1);
      chk($sformatf("vec%0d_ovalid", v), DW'(ovalid), DW'(1));
      chk($sformatf("vec%0d_dout", v), dout, words(vecs[v].exp0, vecs[v].exp1, vecs[v].exp7));
      accept();
    end
    chk("no_overflow_yet", DW'(overflow), DW'(0));

    // Overwrite while the previous frame is pending.
    do_reset();
    run_frame(3, 32'h3, 32'h0, 32'h0, 1'b0, -1, 1'b0);
    step(); step(); step();
    chk("hold_ovalid", DW'(ovalid), DW'(1));
    chk("hold_dout", dout, words(32'h3, 32'h0, 32'h0));
    run_frame(3, 32'h9, 32'h0, 32'h0, 1'b0, -1, 1'b0);
    chk("ovf_set", DW'(overflow), DW'(1));
    chk("ovf_dout", dout, words(32'h9, 32'h0, 32'h0));
    chk("ovf_ovalid", DW'(ovalid), DW'(1));

    // A completion coinciding with acceptance is not an overflow.
    do_reset();
    run_frame(3, 32'h3, 32'h0, 32'h0, 1'b0, -1, 1'b0);
    run_frame(3, 32'hC, 32'h6, 32'h0, 1'b1, -1, 1'b0);
    chk("acc_ovf_clear", DW'(overflow), DW'(0));
    chk("acc_ovalid", DW'(ovalid), DW'(1));
    chk("acc_dout", dout, words(32'hC, 32'h6, 32'h0));
    accept();
    chk("acc_done", DW'(ovalid), DW'(0));

    // Restart at E2 of a bd=4 frame is ignored but flagged.
    do_reset();
    run_frame(3, 32'hB, 32'h4, 32'h0, 1'b0, 1, 1'b1);
    chk("se_starterr", DW'(starterr), DW'(1));
    chk("se_dout", dout, words(32'hB, 32'h4, 32'h0));
    chk("se_busy", DW'(busy), DW'(0));

    // A start on the completing edge also counts as a start in SHIFT.
    accept();
    do_reset();
    run_frame(1, 32'h1, 32'h0, 32'h0, 1'b0, 1, 1'b1);
    chk("se_last_starterr", DW'(starterr), DW'(1));
    chk("se_last_idle", DW'(busy), DW'(0));
    accept();
    step();
    chk("starterr_sticky", DW'(starterr), DW'(1));

    // clr at E2 of a bd=8 frame discards it.
    bdout = 5'd7; start = 1'b1;
    step();                        // E0
    start = 1'b0; din = 8'hFF;
    step();                        // E1
    clr = 1'b1;
    step();                        // E2
    clr = 1'b0;
    chk("mid_clr_dout", dout, '0);
    chk("mid_clr_ovalid", DW'(ovalid), DW'(0));
    chk("mid_clr_busy", DW'(busy), DW'(0));
    chk("mid_clr_starterr", DW'(starterr), DW'(0));
    chk("mid_clr_overflow", DW'(overflow), DW'(0));
    for (int i = 0; i < 8; i++) step();
    chk("mid_clr_no_pulse", DW'(ovalid), DW'(0));
    run_frame(1, 32'h2, 32'h3, 32'h1, 1'b0, -1, 1'b1);
    chk("post_clr_dout", dout, words(32'h2, 32'h3, 32'h1));
    chk("post_clr_ovalid", DW'(ovalid), DW'(1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
